// File: rtl/text_tile_gen.sv
// Character-cell text overlay: buffer-backed tile generator with a power-up clear sequence.
// Optional blink attribute compiled in with `define TEXT_TILE_BLINK_EN.
module text_tile_gen #(
  parameter int CHAR_COLS = 8,
  parameter int CHAR_ROWS = 2,
  parameter int ORG_X     = 0,
  parameter int ORG_Y     = 0,
  localparam int N  = CHAR_COLS * CHAR_ROWS,
  localparam int AW = (N > 1) ? $clog2(N) : 1,
`ifdef TEXT_TILE_BLINK_EN
  localparam int CW = 8
`else
  localparam int CW = 7
`endif
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          video_on,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          frame_tick,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  output logic          busy,
  output logic [10:0]   rom_addr,
  output logic [2:0]    bit_addr,
  output logic          text_on
);

  localparam logic [9:0]  ORG_X10 = 10'(ORG_X);
  localparam logic [9:0]  ORG_Y10 = 10'(ORG_Y);
  localparam logic [10:0] WIN_W   = 11'(CHAR_COLS * 8);
  localparam logic [10:0] WIN_H   = 11'(CHAR_ROWS * 16);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state;
  logic [AW-1:0] clr_ptr;

  logic [CW-1:0] mem [N];
  logic [CW-1:0] rd_data;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [CW-1:0] mem_wd;

  logic [9:0]    dx, dy;
  logic          in_win;
  logic [15:0]   idx_full;
  logic [AW-1:0] rd_idx;

  logic          s1_win, s1_vid;
  logic [3:0]    s1_grow;
  logic [2:0]    s1_bit;
  logic          hide;

  assign dx     = pixel_x - ORG_X10;
  assign dy     = pixel_y - ORG_Y10;
  assign in_win = (pixel_x >= ORG_X10) && ({1'b0, dx} < WIN_W) &&
                  (pixel_y >= ORG_Y10) && ({1'b0, dy} < WIN_H);

  // Address is formed combinationally so the buffer read lands in stage 1.
  assign idx_full = 16'(dy[9:4]) * 16'(CHAR_COLS) + 16'(dx[9:3]);
  assign rd_idx   = in_win ? idx_full[AW-1:0] : '0;

  // Clear sequence owns the write port; host writes only in RUN.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (state == CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clr_ptr;
    end else if (wr_en && (32'(wr_addr) < 32'(N))) begin
      mem_we = 1'b1;
      mem_wa = wr_addr;
      mem_wd = wr_data;
    end
  end

  always_ff @(posedge clk)
    if (mem_we) mem[mem_wa] <= mem_wd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_ptr == AW'(N - 1)) begin
            state <= RUN;
            busy  <= 1'b0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TEXT_TILE_BLINK_EN
  logic [5:0] blink_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        blink_cnt <= '0;
    else if (frame_tick) blink_cnt <= blink_cnt + 6'd1;
  end

  assign hide = rd_data[7] & blink_cnt[5];
`else
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
  assign hide              = 1'b0;
`endif

  // Stage 1: window decode + buffer read (read-first); stage 2: outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      s1_win   <= 1'b0;
      s1_vid   <= 1'b0;
      s1_grow  <= '0;
      s1_bit   <= '0;
      rom_addr <= '0;
      bit_addr <= '0;
      text_on  <= 1'b0;
    end else begin
      rd_data  <= mem[rd_idx];
      s1_win   <= in_win;
      s1_vid   <= video_on;
      s1_grow  <= dy[3:0];
      s1_bit   <= dx[2:0];
      rom_addr <= s1_win ? {rd_data[6:0], s1_grow} : {7'h00, s1_grow};
      bit_addr <= s1_bit;
      text_on  <= s1_win & s1_vid & ~hide;
    end
  end

endmodule

// File: tb/tb_text_tile_gen.sv
// Directed bench for text_tile_gen on a 4x2 cell window at origin 0.
// Blink checks run only when built with TEXT_TILE_BLINK_EN.
module tb_text_tile_gen;

`ifdef TEXT_TILE_BLINK_EN
  localparam int CW = 8;
`else
  localparam int CW = 7;
`endif
  localparam int NC = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          video_on = 1'b0;
  logic [9:0]    pixel_x = '0;
  logic [9:0]    pixel_y = '0;
  logic          frame_tick = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic          busy;
  logic [10:0]   rom_addr;
  logic [2:0]    bit_addr;
  logic          text_on;

  int n_tests = 0;
  int n_fail  = 0;

  text_tile_gen #(.CHAR_COLS(4), .CHAR_ROWS(2), .ORG_X(0), .ORG_Y(0)) dut (
    .clk(clk), .reset_n(reset_n), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_tick(frame_tick),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .rom_addr(rom_addr), .bit_addr(bit_addr), .text_on(text_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vid;
    logic [10:0] rom;
    logic [2:0]  bit_a;
    logic        on;
  } vec_t;

  vec_t vt[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = CW'(d);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic v);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = v;
  endtask

  // Counts samples with busy high starting right after reset release.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    int cnt;
    vt[0] = '{"cell5_hit",      10'd13, 10'd21, 1'b1, 11'h415, 3'd5, 1'b1};
    vt[1] = '{"right_outside",  10'd32, 10'd0,  1'b1, 11'h000, 3'd0, 1'b0};
    vt[2] = '{"cell1_blank",    10'd10, 10'd2,  1'b1, 11'h002, 3'd2, 1'b1};
    vt[3] = '{"cell2_wr_lost",  10'd16, 10'd5,  1'b1, 11'h005, 3'd0, 1'b1};
    vt[4] = '{"video_off",      10'd13, 10'd21, 1'b0, 11'h415, 3'd5, 1'b0};
    vt[5] = '{"last_pixel",     10'd31, 10'd31, 1'b1, 11'h00f, 3'd7, 1'b1};
    vt[6] = '{"below_outside",  10'd0,  10'd32, 1'b1, 11'h000, 3'd0, 1'b0};
    vt[7] = '{"both_outside",   10'd37, 10'd20, 1'b1, 11'h004, 3'd5, 1'b0};
    vt[8] = '{"cell5_corner",   10'd8,  10'd16, 1'b1, 11'h410, 3'd0, 1'b1};

    // Reset state, with live pixel inputs that must not leak through.
    pix(13, 21, 1'b1);
    step(); step(); step();
    chk("rst_rom",  16'(rom_addr), 16'h0);
    chk("rst_bit",  16'(bit_addr), 16'h0);
    chk("rst_on",   16'(text_on),  16'h0);
    chk("rst_busy", 16'(busy),     16'h1);

    // Release; hold a write to cell 2 for the whole clear so it must be dropped.
    reset_n = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = CW'(7'h7f);
    count_busy(cnt);
    wr_en = 1'b0;
    chk("clear_len", 16'(cnt), 16'(NC));

    wr(5, 'h41);
    foreach (vt[i]) begin
      pix(int'(vt[i].x), int'(vt[i].y), vt[i].vid);
      step(); step();
      chk({vt[i].nm, "_rom"}, 16'(rom_addr), 16'(vt[i].rom));
      chk({vt[i].nm, "_bit"}, 16'(bit_addr), 16'(vt[i].bit_a));
      chk({vt[i].nm, "_on"},  16'(text_on),  16'(vt[i].on));
    end

    // Read-first: a read issued with the write sees old data, the next one new.
    pix(16, 16, 1'b1);
    wr(6, 'h22);
    step();
    chk("rdfirst_old", 16'(rom_addr), 16'h000);
    step();
    chk("rdfirst_new", 16'(rom_addr), 16'h220);

    // Continuous sweep across row 0, one pixel per cycle.
    wr(3, 'h33);
    for (int i = 0; i < 34; i++) begin
      pix((i < 32) ? i : 0, 0, 1'b1);
      step();
      if (i >= 2) begin
        chk("sweep_bit", 16'(bit_addr), 16'((i - 1) % 8));
        chk("sweep_rom", 16'(rom_addr), ((i - 1) / 8 == 3) ? 16'h330 : 16'h000);
        chk("sweep_on",  16'(text_on),  16'h1);
      end
    end

`ifdef TEXT_TILE_BLINK_EN
    wr(0, 'hc1);
    pix(0, 0, 1'b1);
    step(); step();
    chk("blink_pre_on",  16'(text_on),  16'h1);
    chk("blink_pre_rom", 16'(rom_addr), 16'h410);
    for (int i = 0; i < 32; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
    step(); step();
    chk("blink_off_on",  16'(text_on),  16'h0);
    chk("blink_off_rom", 16'(rom_addr), 16'h410);
`endif

    // Asynchronous reset mid-sweep clears outputs at once and restarts the clear.
    for (int i = 0; i < 6; i++) begin
      pix(8 + i, 16, 1'b1);
      step();
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_rom",  16'(rom_addr), 16'h0);
    chk("midrst_bit",  16'(bit_addr), 16'h0);
    chk("midrst_on",   16'(text_on),  16'h0);
    chk("midrst_busy", 16'(busy),     16'h1);
    step();
    reset_n = 1'b1;
    count_busy(cnt);
    chk("reclear_len", 16'(cnt), 16'(NC));
    pix(13, 21, 1'b1);
    step(); step();
    chk("reclear_cell5", 16'(rom_addr), 16'h005);
    chk("reclear_on",    16'(text_on),  16'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/text_tile_gen.md
TEXT_TILE_GEN -- requirements
Module: text_tile_gen

Interface
REQ-001 Parameter CHAR_COLS, 8: characters per text row (1..80).
REQ-002 Parameter CHAR_ROWS, 2: text rows (1..30).
REQ-003 Parameter ORG_X, 0: pixel column of the text window's left edge (10-bit).
REQ-004 Parameter ORG_Y, 0: pixel line of the text window's top edge (10-bit).
REQ-005 Derived constants: N = CHAR_COLS*CHAR_ROWS; AW = clog2(N), minimum 1; glyph cell = 8 px wide by 16 lines high.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  system/pixel clock; all state is on the rising edge.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 video_on  in  1  visible-area flag from the sync generator.
REQ-010 pixel_x  in  10  current pixel column.
REQ-011 pixel_y  in  10  current pixel line.
REQ-012 frame_tick  in  1  one-cycle pulse per frame.
REQ-013 wr_en  in  1  character buffer write strobe.
REQ-014 wr_addr  in  AW  buffer cell index, row*CHAR_COLS+col.
REQ-015 wr_data  in  CW  character code; CW = 8 with BLINK_EN, otherwise 7.
REQ-016 busy  out  1  clear sequence in progress.
REQ-017 rom_addr  out  11  font ROM address {code[6:0], glyph_row[3:0]}.
REQ-018 bit_addr  out  3  glyph column, for the pixel mux.
REQ-019 text_on  out  1  current pixel lies in the text window and is shown.

Function
REQ-020 Character buffer: N words of CW bits, synchronous read-first; a read and a write to the same cell in the same cycle return the old data.
REQ-021 Stage 1 registers the following from the sampled inputs:
- dx = pixel_x-ORG_X and dy = pixel_y-ORG_Y (10-bit, wrap ignored);
- in_win = (pixel_x>=ORG_X) & (dx<CHAR_COLS*8) & (pixel_y>=ORG_Y) & (dy<CHAR_ROWS*16);
- col = dx[9:3], row = dy[9:4], glyph_row = dy[3:0], bit_addr = dx[2:0], video_on.
REQ-022 Stage 1 issues the buffer read at index row*CHAR_COLS+col; outside the window the index is 0.
REQ-023 Stage 2 registers all outputs. Latency from pixel inputs to rom_addr, bit_addr and text_on is exactly 2 clk cycles, with full throughput of one pixel per cycle.
REQ-024 Inside the window, rom_addr = {code[6:0], glyph_row}. Outside it, rom_addr = {7'h00, glyph_row} and text_on = 0.
REQ-025 text_on = in_win & video_on (stage-aligned), further gated by REQ-034.
REQ-026 Clear FSM states are CLEAR and RUN.
- Reset enters CLEAR, with clr_ptr = 0 and busy = 1.
- In CLEAR, the FSM writes 0 to cell clr_ptr each cycle and increments clr_ptr.
- After writing cell N-1, it moves to RUN and busy = 0; CLEAR lasts exactly N cycles.
REQ-027 While busy = 1, wr_en is ignored and the write is lost. Outputs still follow REQ-023, reading cleared or pending cells.
REQ-028 In RUN, wr_en writes wr_data to wr_addr. wr_addr >= N is ignored and the buffer is unchanged.
REQ-029 There is no other interaction between writes and the read pipeline; write data becomes visible to a read issued the cycle after the write.

Reset
REQ-030 While reset_n = 0, the following hold:
- rom_addr = 0, bit_addr = 0, text_on = 0, busy = 1;
- all pipeline registers are 0, and the blink counter is 0 if present.
REQ-031 reset_n asserted mid-frame or mid-CLEAR aborts the operation immediately. Release restarts CLEAR from cell 0, and the first valid output appears 2 cycles after release.
REQ-032 Buffer contents are not reset directly; they are defined only after CLEAR completes.

Configuration
REQ-033 Macro TEXT_TILE_BLINK_EN selects whether blinking is compiled in.
REQ-034 With TEXT_TILE_BLINK_EN defined, CW = 8 and wr_data[7] is the blink attribute.
- A 6-bit frame counter increments on each frame_tick and wraps 63->0.
- When the counter's bit 5 = 1, a cell with attribute 1 drives text_on = 0; rom_addr is unaffected.
REQ-035 Without TEXT_TILE_BLINK_EN, CW = 7, there is no frame counter, and frame_tick is ignored.

Verification
REQ-036 Parameters CHAR_COLS=4, CHAR_ROWS=2, origin 0. Release reset, observe busy for 8 cycles, then write cell 5 = 7'h41. Apply x=13, y=21, video_on=1 -> 2 cycles later rom_addr = 11'h415, bit_addr = 5, text_on = 1.
REQ-037 With the REQ-036 setup, apply x=32, y=0 (outside the window) -> 2 cycles later text_on = 0 and rom_addr = 11'h000.
REQ-038 During CLEAR, pulse wr_en with addr 2 and data 7'h7F, then read cell 2 after busy falls -> code 0, i.e. rom_addr[10:4] = 0.
REQ-039 Drive a continuous x sweep 0..31 on y=0 -> outputs follow the inputs with a 2-cycle lag and no bubbles; bit_addr cycles 0..7.
REQ-040 With TEXT_TILE_BLINK_EN, write cell 0 = 8'hC1 and issue 32 frame_ticks -> text_on at x=0 toggles 1 to 0, and rom_addr stays {7'h41, row}.
REQ-041 Assert reset_n low mid-sweep -> outputs 0 immediately; after release busy = 1 for N cycles and previously written cells read 0.
